// File: rtl/vga_timing_gen_if.sv
//==============================================================================
// Module  : vga_timing_gen_if
// Brief   : Raster position, blanking, sync and animation signals from the
//           VGA timing generator to the sprite mapper.
// Rev     : 1.0
//==============================================================================
`default_nettype none

interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic        anim_sel;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, anim_sel, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, anim_sel, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module  : vga_timing_gen
// Brief   : 640x480@60Hz raster timing with latency-matched hs/vs, a frame
//           start pulse, a frame counter and a slow animation-frame toggle.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2,
  parameter int ANIM_DIV   = 15
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam int              ANIM_W    = (ANIM_DIV < 2) ? 1 : $clog2(ANIM_DIV);
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);

  logic [9:0]        hc;
  logic [9:0]        vc;
  logic [9:0]        hc_nxt;
  logic [9:0]        vc_nxt;
  logic              hs_raw;
  logic              vs_raw;
  logic              origin;
  logic              hs_now;
  logic              vs_now;
  logic [ANIM_W-1:0] anim_cnt;

  // Everything downstream is derived from the position the counters are
  // about to take, so all registered outputs describe the same pixel.
  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
    end
    hs_raw = !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
    vs_raw = !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
    origin = (hc_nxt == '0) && (vc_nxt == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc              <= H_LAST;
      vc              <= V_LAST;
      vga.DrawX       <= '0;
      vga.DrawY       <= '0;
      vga.blank       <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.anim_sel    <= 1'b0;
      vga.frame_count <= '0;
      anim_cnt        <= '0;
      hs_now          <= 1'b1;
      vs_now          <= 1'b1;
    end else begin
      hc              <= hc_nxt;
      vc              <= vc_nxt;
      vga.DrawX       <= hc_nxt;
      vga.DrawY       <= vc_nxt;
      vga.blank       <= (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
      vga.frame_start <= origin;
      hs_now          <= hs_raw;
      vs_now          <= vs_raw;
      if (origin) begin
        vga.frame_count <= vga.frame_count + 16'd1;
        if (anim_cnt == ANIM_LAST) begin
          anim_cnt     <= '0;
          vga.anim_sel <= ~vga.anim_sel;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end
    end
  end

  // Sync outputs trail the position by PIPE_DELAY clocks to line up with the
  // mapper's ROM read; reset refills the line with the inactive level.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign vga.hs = hs_now;
      assign vga.vs = vs_now;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe;
      logic [PIPE_DELAY-1:0] vs_pipe;

      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs_now;
          vs_pipe[0] <= vs_now;
          for (int i = PIPE_DELAY - 1; i > 0; i--) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign vga.hs = hs_pipe[PIPE_DELAY-1];
      assign vga.vs = vs_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//==============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Scoreboarded bench for vga_timing_gen (full-size and reduced
//           raster instances) plus directed timing checks.
// Rev     : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        anim;
    logic [15:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n = 3'b000;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();
  vga_timing_gen_if ic ();

  // a: full 640x480 raster, PIPE_DELAY 2
  vga_timing_gen dut_a (.vga_clk(clk), .reset_n(rst_n[0]), .vga(ia));

  // b: 16x10 raster, no sync delay, default ANIM_DIV
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(0), .ANIM_DIV(15)
  ) dut_b (.vga_clk(clk), .reset_n(rst_n[1]), .vga(ib));

  // c: 16x10 raster, 2-clock sync delay, toggle every frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(2), .ANIM_DIV(1)
  ) dut_c (.vga_clk(clk), .reset_n(rst_n[2]), .vga(ic));

  exp_t act [3];
  assign act[0] = {ia.DrawX, ia.DrawY, ia.blank, ia.hs, ia.vs, ia.frame_start, ia.anim_sel, ia.frame_count};
  assign act[1] = {ib.DrawX, ib.DrawY, ib.blank, ib.hs, ib.vs, ib.frame_start, ib.anim_sel, ib.frame_count};
  assign act[2] = {ic.DrawX, ic.DrawY, ic.blank, ic.hs, ic.vs, ic.frame_start, ic.anim_sel, ic.frame_count};

  // Expected outputs after the k-th clock edge with reset released (k=0: in reset).
  function automatic exp_t model(int idx, longint k);
    exp_t   e;
    longint hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, pd, ad;
    longint ht, vt, fl, p, f, q;
    if (idx == 0) begin
      hv = 640; hfp = 16; hsw = 96; hbp = 48;
      vv = 480; vfp = 10; vsw = 2;  vbp = 33;
      pd = 2;   ad = 15;
    end else begin
      hv = 8; hfp = 2; hsw = 3; hbp = 3;
      vv = 6; vfp = 1; vsw = 2; vbp = 1;
      pd = (idx == 1) ? 0 : 2;
      ad = (idx == 1) ? 15 : 1;
    end
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k == 0) return e;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    fl = ht * vt;
    p  = (k - 1) % fl;
    f  = (k - 1) / fl + 1;
    e.dx    = 10'(p % ht);
    e.dy    = 10'(p / ht);
    e.blank = ((p % ht) < hv) && ((p / ht) < vv);
    e.fs    = (p == 0);
    e.fc    = 16'(f % 65536);
    e.anim  = ((f / ad) % 2) == 1;
    if (k - pd >= 1) begin
      q    = (k - pd - 1) % fl;
      e.hs = !(((q % ht) >= hv + hfp) && ((q % ht) < hv + hfp + hsw));
      e.vs = !(((q / ht) >= vv + vfp) && ((q / ht) < vv + vfp + vsw));
    end
    return e;
  endfunction

  exp_t   sbq [3][$];
  longint kc  [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) kc[i] = 0;
      else           kc[i] = kc[i] + 1;
      sbq[i].push_back(model(i, kc[i]));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sbq[i].size() > 0) begin
        exp_t e;
        e = sbq[i].pop_front();
        n_chk++;
        if (act[i] !== e) begin
          n_fail++;
          $display("FAIL sb_dut%0d t=%0t: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b anim=%b fc=%0d, expected x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b anim=%b fc=%0d",
                   i, $time, act[i].dx, act[i].dy, act[i].blank, act[i].hs, act[i].vs, act[i].fs, act[i].anim, act[i].fc,
                   e.dx, e.dy, e.blank, e.hs, e.vs, e.fs, e.anim, e.fc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  initial begin
    int   nb, nh, c656, cfall;
    int   nfs, last_fs, fs_int, bfall_dx, cb, cv, c07, vfall;
    int   tog_fc [$];
    logic prev_hs, prev_anim, prev_hsb, prev_vsc, found;

    repeat (5) tick();
    check("rst_dx",    ia.DrawX, 0);
    check("rst_dy",    ia.DrawY, 0);
    check("rst_blank", ia.blank, 0);
    check("rst_hs",    ia.hs, 1);
    check("rst_vs",    ia.vs, 1);
    check("rst_anim",  ia.anim_sel, 0);
    check("rst_fs",    ia.frame_start, 0);
    check("rst_fc",    ia.frame_count, 0);

    rst_n[0] = 1'b1;
    tick();
    check("first_dx",    ia.DrawX, 0);
    check("first_dy",    ia.DrawY, 0);
    check("first_blank", ia.blank, 1);
    check("first_fs",    ia.frame_start, 1);
    check("first_fc",    ia.frame_count, 1);

    // One full line on the full-size raster
    nb = 0; nh = 0; c656 = -1; cfall = -1; prev_hs = ia.hs;
    for (int i = 0; i < 800; i++) begin
      if (ia.blank) nb++;
      if (!ia.hs) nh++;
      if (ia.DrawX == 10'd656 && c656 < 0) c656 = i;
      if (prev_hs && !ia.hs && cfall < 0) cfall = i;
      prev_hs = ia.hs;
      tick();
    end
    check("line_blank_cnt", nb, 640);
    check("line_hs_low_cnt", nh, 96);
    check("hs_fall_after_656", cfall - c656, 2);
    check("line_wrap_dx", ia.DrawX, 0);
    check("line_wrap_dy", ia.DrawY, 1);
    check("line_wrap_fs", ia.frame_start, 0);

    // Reduced rasters: 31 frames of b, first-frame timing of c
    rst_n[2:1] = 2'b11;
    tick();
    nfs = 0; last_fs = -1; fs_int = -1; bfall_dx = -1;
    cb = 0; cv = 0; c07 = -1; vfall = -1;
    prev_anim = ib.anim_sel; prev_hsb = ib.hs; prev_vsc = ic.vs;
    for (int i = 0; i < 4800; i++) begin
      if (ib.frame_start) begin
        nfs++;
        if (last_fs >= 0 && fs_int < 0) fs_int = i - last_fs;
        last_fs = i;
      end
      if (ib.anim_sel != prev_anim) tog_fc.push_back(int'(ib.frame_count));
      prev_anim = ib.anim_sel;
      if (prev_hsb && !ib.hs && bfall_dx < 0) bfall_dx = int'(ib.DrawX);
      prev_hsb = ib.hs;
      if (i == 159) begin
        check("b_last_dx", ib.DrawX, 15);
        check("b_last_dy", ib.DrawY, 9);
      end
      if (i == 160) begin
        check("b_wrap_pos", {ib.DrawX, ib.DrawY}, 0);
        check("b_wrap_fs", ib.frame_start, 1);
        check("b_wrap_fc", ib.frame_count, 2);
      end
      if (i < 160) begin
        if (ic.blank) cb++;
        if (!ic.vs) cv++;
        if (ic.DrawX == 10'd0 && ic.DrawY == 10'd7 && c07 < 0) c07 = i;
        if (prev_vsc && !ic.vs && vfall < 0) vfall = i;
      end
      prev_vsc = ic.vs;
      tick();
    end
    check("b_fs_count", nfs, 30);
    check("b_fs_interval", fs_int, 160);
    check("b_hs_fall_dx", bfall_dx, 10);
    check("c_frame_blank_cnt", cb, 48);
    check("c_frame_vs_low_cnt", cv, 32);
    check("c_vs_fall_after_0_7", vfall - c07, 2);
    check("b_anim_toggles", tog_fc.size(), 2);
    if (tog_fc.size() == 2) begin
      check("b_anim_toggle1_fc", tog_fc[0], 15);
      check("b_anim_toggle2_fc", tog_fc[1], 30);
    end
    check("b_fc_31", ib.frame_count, 31);
    check("b_fs_31", ib.frame_start, 1);
    check("b_anim_31", ib.anim_sel, 0);

    // Mid-frame reset on b while hs is inactive
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (ib.DrawX == 10'd5 && ib.DrawY == 10'd3) found = 1'b1;
      else tick();
    end
    if (!found) timeout("b_wait_5_3");
    check("b_pre_rst_hs", ib.hs, 1);
    rst_n[1] = 1'b0;
    tick();
    check("b_mid_rst_pos", {ib.DrawX, ib.DrawY}, 0);
    check("b_mid_rst_blank", ib.blank, 0);
    check("b_mid_rst_fc", ib.frame_count, 0);
    check("b_mid_rst_anim", ib.anim_sel, 0);
    rst_n[1] = 1'b1;
    tick();
    check("b_reentry_pos", {ib.DrawX, ib.DrawY}, 0);
    check("b_reentry_fs", ib.frame_start, 1);
    check("b_reentry_fc", ib.frame_count, 1);
    repeat (160) tick();
    check("b_next_frame_fs", ib.frame_start, 1);
    check("b_next_frame_fc", ib.frame_count, 2);

    // Reset on c during its vsync pulse must not leave a partial pulse behind
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!ic.vs) found = 1'b1;
      else tick();
    end
    if (!found) timeout("c_wait_vs_low");
    rst_n[2] = 1'b0;
    tick();
    check("c_mid_rst_vs", ic.vs, 1);
    rst_n[2] = 1'b1;
    tick();
    check("c_reentry_vs", ic.vs, 1);
    check("c_reentry_pos", {ic.DrawX, ic.DrawY}, 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
